// File: rtl/regfile_scoreboard.sv
// Register file with two registered read ports, one write port and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to the read ports (data and ready).
module regfile_scoreboard #(
    parameter int                 DATA_W  = 16,
    parameter int                 ADDR_W  = 3,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic [DATA_W-1:0]        rd_data_a,
    output logic [DATA_W-1:0]        rd_data_b,
    output logic                     rd_rdy_a,
    output logic                     rd_rdy_b,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(2**ADDR_W)-1:0]   busy,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_nxt;
    logic [DATA_W-1:0] src_data_a, src_data_b;
    logic              src_rdy_a, src_rdy_b;

    // Reservation is applied after the write release so a new producer wins a collision.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (rsv_en) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        src_data_a = mem[rd_addr_a];
        src_data_b = mem[rd_addr_b];
        src_rdy_a  = ~busy_q[rd_addr_a];
        src_rdy_b  = ~busy_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        // A forwarded write still counts as pending if it is re-reserved in the same cycle.
        if (wr_en && (wr_addr == rd_addr_a)) begin
            src_data_a = wr_data;
            src_rdy_a  = ~(rsv_en && (rsv_addr == rd_addr_a));
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            src_data_b = wr_data;
            src_rdy_b  = ~(rsv_en && (rsv_addr == rd_addr_b));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= RST_VAL;
            end
            busy_q    <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_rdy_a  <= 1'b0;
            rd_rdy_b  <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            busy_q <= busy_nxt;
            if (rd_en) begin
                rd_data_a <= src_data_a;
                rd_data_b <= src_data_b;
                rd_rdy_a  <= src_rdy_a;
                rd_rdy_b  <= src_rdy_b;
            end
        end
    end

    assign busy     = busy_q;
    assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed reads push expected operands, a monitor pops and compares.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [2:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_rdy_a, rd_rdy_b;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic [7:0]  busy;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ra;
        logic        rb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic out_valid = 1'b0;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W (16),
        .ADDR_W (3),
        .RST_VAL(16'h0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .rd_rdy_a (rd_rdy_a),
        .rd_rdy_b (rd_rdy_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy     (busy),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // A read sampled at a non-reset edge produces operands visible after that edge.
    always @(posedge clk) out_valid <= rd_en && !rst;

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_data_a", {16'h0, rd_data_a}, {16'h0, e.a});
                chk("rd_data_b", {16'h0, rd_data_b}, {16'h0, e.b});
                chk("rd_rdy_a", {31'h0, rd_rdy_a}, {31'h0, e.ra});
                chk("rd_rdy_b", {31'h0, rd_rdy_b}, {31'h0, e.rb});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b, input exp_t e);
        rd_en     = 1'b1;
        rd_addr_a = a;
        rd_addr_b = b;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
    endtask

    task automatic rsv(input logic [2:0] addr);
        rsv_en   = 1'b1;
        rsv_addr = addr;
    endtask

    task automatic chk_dbg(input string name, input logic [2:0] addr, input logic [15:0] req);
        dbg_addr = addr;
        #1;
        chk(name, {16'h0, dbg_data}, {16'h0, req});
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; dbg_addr = '0;

        // Reset with a write and read presented: both discarded.
        repeat (2) begin
            wr(3'd2, 16'h1234);
            rsv(3'd2);
            rd_en = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
            step();
        end
        chk("rst_busy", {24'h0, busy}, 32'h0);
        chk("rst_rd_data_a", {16'h0, rd_data_a}, 32'h0);
        chk("rst_rd_data_b", {16'h0, rd_data_b}, 32'h0);
        chk("rst_rdy", {30'h0, rd_rdy_a, rd_rdy_b}, 32'h0);
        chk_dbg("rst_dbg_r2", 3'd2, 16'h0000);
        rst = 1'b0;

        wr(3'd1, 16'd1000); step();
        chk_dbg("dbg_r1", 3'd1, 16'd1000);
        rd(3'd1, 3'd1, '{a: 16'd1000, b: 16'd1000, ra: 1'b1, rb: 1'b1}); step();

        rsv(3'd3); step();
        chk("busy_rsv3", {24'h0, busy}, 32'h08);
        rd(3'd3, 3'd1, '{a: 16'd0, b: 16'd1000, ra: 1'b0, rb: 1'b1}); step();
        wr(3'd3, 16'd5); step();
        chk("busy_wr3", {24'h0, busy}, 32'h00);
        rd(3'd3, 3'd3, '{a: 16'd5, b: 16'd5, ra: 1'b1, rb: 1'b1}); step();

        // Same-cycle write and read of a reserved register.
        rsv(3'd4); step();
        wr(3'd4, 16'd10000);
`ifdef REGFILE_BYPASS_EN
        rd(3'd4, 3'd1, '{a: 16'd10000, b: 16'd1000, ra: 1'b1, rb: 1'b1});
`else
        rd(3'd4, 3'd1, '{a: 16'd0, b: 16'd1000, ra: 1'b0, rb: 1'b1});
`endif
        step();
        chk_dbg("dbg_r4", 3'd4, 16'd10000);

        // Same-cycle write, reserve and read of R6.
        wr(3'd6, 16'd33); rsv(3'd6);
`ifdef REGFILE_BYPASS_EN
        rd(3'd6, 3'd6, '{a: 16'd33, b: 16'd33, ra: 1'b0, rb: 1'b0});
`else
        rd(3'd6, 3'd6, '{a: 16'd0, b: 16'd0, ra: 1'b1, rb: 1'b1});
`endif
        step();
        chk("busy_r6", {24'h0, busy}, 32'h40);

        rsv(3'd5); step();
        wr(3'd5, 16'd7); rsv(3'd5); step();
        chk_dbg("dbg_r5", 3'd5, 16'd7);
        chk("busy_collide", {24'h0, busy}, 32'h60);

        rd(3'd1, 3'd2, '{a: 16'd1000, b: 16'd0, ra: 1'b1, rb: 1'b1}); step();
        wr(3'd1, 16'hFFFF); step();
        chk("hold_a_1", {16'h0, rd_data_a}, {16'h0, 16'd1000});
        step();
        chk("hold_a_2", {16'h0, rd_data_a}, {16'h0, 16'd1000});
        rd(3'd1, 3'd5, '{a: 16'hFFFF, b: 16'd7, ra: 1'b1, rb: 1'b0}); step();

        // Reset during a read: the read is lost and outputs clear.
        rst = 1'b1; rd_en = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd5; step();
        rst = 1'b0;
        chk("midrst_data", {rd_data_a, rd_data_b}, 32'h0);
        chk("midrst_rdy", {30'h0, rd_rdy_a, rd_rdy_b}, 32'h0);
        chk("midrst_busy", {24'h0, busy}, 32'h0);
        chk_dbg("midrst_dbg_r1", 3'd1, 16'h0000);

        step(); step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
